ps2_osd_keys: RTL and testbench

//  PS/2 keyboard receiver + scan-code decoder; upstream of the OSD SPI RAM/BTN slave.

---
 rtl/ps2_scancode_pkg.sv | 44 ++++
 rtl/ps2_rx.sv | 140 ++++++++++++++
 rtl/ps2_osd_keys.sv | 133 +++++++++++++
 tb/tb_ps2_osd_keys.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_pkg.sv
// Scan-code constants, receiver state encoding and cursor bit positions shared
// by the PS/2 receiver and the OSD key decoder.
package ps2_scancode_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam int CUR_UP    = 0;
  localparam int CUR_DOWN  = 1;
  localparam int CUR_LEFT  = 2;
  localparam int CUR_RIGHT = 3;

  // Bytes following E1 that belong to the Pause sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // One-hot cursor bit for an arrow / keypad scan code, zero otherwise.
  function automatic logic [3:0] cursor_onehot(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[CUR_UP]    = 1'b1;
      SC_DOWN:  m[CUR_DOWN]  = 1'b1;
      SC_LEFT:  m[CUR_LEFT]  = 1'b1;
      SC_RIGHT: m[CUR_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: line synchronisers, ps2_clk glitch filter,
// 11-bit frame FSM with odd parity check and a mid-frame watchdog.
module ps2_rx
  import ps2_scancode_pkg::*;
#(
  parameter int c_filter_bits  = 4,
  parameter int c_timeout_bits = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_abort
);

  logic [1:0]                clk_sync_q, clk_sync_d;
  logic [1:0]                data_sync_q, data_sync_d;
  logic [c_filter_bits-1:0]  filt_q, filt_d;
  logic                      clk_f_q, clk_f_d;
  rx_state_e                 state_q, state_d;
  logic [2:0]                bitcnt_q, bitcnt_d;
  logic [7:0]                shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic [c_timeout_bits-1:0] wdog_q, wdog_d;
  logic [7:0]                byte_q, byte_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      abort_q, abort_d;
  logic                      fall;
  logic                      data_bit;

  assign data_bit = data_sync_q[1];
  assign fall     = clk_f_q & ~clk_f_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = {filt_q[c_filter_bits-2:0], clk_sync_q[1]};
    clk_f_d     = clk_f_q;
    if (&filt_q)       clk_f_d = 1'b1;
    else if (~|filt_q) clk_f_d = 1'b0;

    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    abort_d  = 1'b0;
    wdog_d   = wdog_q + c_timeout_bits'(1);
    if (state_q == IDLE || fall) wdog_d = '0;

    case (state_q)
      IDLE: begin
        if (fall && !data_bit) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {data_bit, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (data_bit && (^{shift_q, parity_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the expiry cycle is still honoured above.
    if (!fall && state_q != IDLE && wdog_q[c_timeout_bits-1]) begin
      state_d = IDLE;
      wdog_d  = '0;
      abort_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, checked inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= '1;
      clk_f_q     <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      wdog_q      <= '0;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      clk_f_q     <= clk_f_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      wdog_q      <= wdog_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign rx_abort = abort_q;

endmodule

// File: rtl/ps2_osd_keys.sv
// PS/2 keyboard front end for the OSD: held state of F1 and the arrow keys.
// Optional PS2_OSD_NUMPAD_EN: non-extended keypad 8/2/4/6 also drive the cursor bits.
module ps2_osd_keys
  import ps2_scancode_pkg::*;
#(
  parameter int c_filter_bits  = 4,
  parameter int c_timeout_bits = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       parity_err,
  output logic       f1_pressed,
  output logic [3:0] cursor_keys_pressed
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_abort;

  ps2_rx #(
    .c_filter_bits (c_filter_bits),
    .c_timeout_bits(c_timeout_bits)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .rx_abort(rx_abort)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       f1_q, f1_d;
  logic [3:0] arrow_q, arrow_d;
  logic [3:0] keypad_q;
  logic [3:0] code_mask;

  assign code_mask = cursor_onehot(rx_byte);

`ifdef PS2_OSD_NUMPAD_EN
  logic [3:0] keypad_d;
`endif

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    f1_d    = f1_q;
    arrow_d = arrow_q;
`ifdef PS2_OSD_NUMPAD_EN
    keypad_d = keypad_q;
`endif
    if (rx_abort) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte)
          SC_E0: ext_d = 1'b1;
          SC_F0: brk_d = 1'b1;
          SC_E1: begin
            skip_d = PAUSE_SKIP;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          SC_BAT: begin
            f1_d    = 1'b0;
            arrow_d = 4'b0000;
`ifdef PS2_OSD_NUMPAD_EN
            keypad_d = 4'b0000;
`endif
          end
          SC_ACK, SC_RESEND, SC_ECHO, SC_ERR0, SC_ERR1: ;
          default: begin
            if (!ext_q && rx_byte == SC_F1)
              f1_d = ~brk_q;
            else if (ext_q)
              arrow_d = brk_q ? (arrow_q & ~code_mask) : (arrow_q | code_mask);
`ifdef PS2_OSD_NUMPAD_EN
            else
              keypad_d = brk_q ? (keypad_q & ~code_mask) : (keypad_q | code_mask);
`endif
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= 3'd0;
      f1_q    <= 1'b0;
      arrow_q <= 4'b0000;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      f1_q    <= f1_d;
      arrow_q <= arrow_d;
    end
  end

`ifdef PS2_OSD_NUMPAD_EN
  always_ff @(posedge clk) begin
    if (reset) keypad_q <= 4'b0000;
    else       keypad_q <= keypad_d;
  end
`else
  assign keypad_q = 4'b0000;
`endif

  assign scancode            = rx_byte;
  assign scancode_valid      = rx_valid;
  assign parity_err          = rx_err;
  assign f1_pressed          = f1_q;
  assign cursor_keys_pressed = arrow_q | keypad_q;

endmodule

// File: tb/tb_ps2_osd_keys.sv
// Bench for ps2_osd_keys: directed and random PS/2 frames with glitches, checked
// against a key-table reference model of the scan-code rules.
module tb_ps2_osd_keys;

  localparam int H        = 30;   // clk cycles per ps2_clk half period
  localparam int TO_BITS  = 10;   // short watchdog keeps the abort test brief

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       parity_err;
  logic       f1_pressed;
  logic [3:0] cursor_keys_pressed;

  always #5 clk = ~clk;

  ps2_osd_keys #(
    .c_filter_bits (4),
    .c_timeout_bits(TO_BITS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ps2_clk            (ps2_clk),
    .ps2_data           (ps2_data),
    .scancode           (scancode),
    .scancode_valid     (scancode_valid),
    .parity_err         (parity_err),
    .f1_pressed         (f1_pressed),
    .cursor_keys_pressed(cursor_keys_pressed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  logic [7:0] last_sc   = 8'h00;

  always @(negedge clk) begin
    if (scancode_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_sc   <= scancode;
    end
    if (parity_err) err_cnt <= err_cnt + 1;
  end

  // Reference model: table of tracked keys as {extended, code}
`ifdef PS2_OSD_NUMPAD_EN
  localparam int N_KEYS = 9;
`else
  localparam int N_KEYS = 5;
`endif
  logic [8:0] key_tab [9] = '{9'h005, 9'h175, 9'h172, 9'h16B, 9'h174,
                              9'h075, 9'h072, 9'h06B, 9'h074};
  logic m_held [9];
  logic m_ext;
  logic m_brk;
  int   m_skip;

  task automatic model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
  endtask

  function automatic int find_key(input logic ext, input logic [7:0] code);
    for (int i = 0; i < N_KEYS; i++)
      if (key_tab[i] == {ext, code}) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    case (b)
      8'hE0: m_ext = 1'b1;
      8'hF0: m_brk = 1'b1;
      8'hE1: begin m_skip = 7; m_ext = 1'b0; m_brk = 1'b0; end
      8'hAA: foreach (m_held[i]) m_held[i] = 1'b0;
      8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
      default: begin
        k = find_key(m_ext, b);
        if (k >= 0) m_held[k] = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    endcase
  endtask

  task automatic check_keys(input string tag);
    logic [3:0] exp_cur;
    for (int i = 0; i < 4; i++) exp_cur[i] = m_held[1+i] | m_held[5+i];
    check({tag, ".f1"}, {31'd0, f1_pressed}, {31'd0, m_held[0]});
    check({tag, ".cursor"}, {28'd0, cursor_keys_pressed}, {28'd0, exp_cur});
  endtask

  // Drive the first nbits of an 11-bit frame, bit 0 first, with optional glitches.
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = frame[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    int v0, e0;
    string tag;
    v0 = valid_cnt;
    e0 = err_cnt;
    tag = $sformatf("byte_%02h%s", b, bad_par ? "_badpar" : "");
    send_bits(make_frame(b, bad_par), 11);
    repeat (20) @(negedge clk);
    if (!bad_par) model_byte(b);
    check({tag, ".valid"}, valid_cnt - v0, bad_par ? 0 : 1);
    check({tag, ".perr"}, err_cnt - e0, bad_par ? 1 : 0);
    if (!bad_par) check({tag, ".scancode"}, {24'd0, last_sc}, {24'd0, b});
    check_keys(tag);
  endtask

  task automatic send_abort(input logic [7:0] b, input int nbits);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(make_frame(b, 1'b0), nbits);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (3 * (1 << (TO_BITS - 1))) @(negedge clk);
    m_ext = 1'b0;
    m_brk = 1'b0;
    check("abort.valid", valid_cnt - v0, 0);
    check("abort.perr", err_cnt - e0, 0);
    check_keys("abort");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".scancode"}, {24'd0, scancode}, 32'd0);
    check({tag, ".valid"}, {31'd0, scancode_valid}, 32'd0);
    check({tag, ".perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, ".f1"}, {31'd0, f1_pressed}, 32'd0);
    check({tag, ".cursor"}, {28'd0, cursor_keys_pressed}, 32'd0);
  endtask

  logic [7:0] pool [16] = '{8'h05, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hE0, 8'hF0,
                            8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h12, 8'h59, 8'h14, 8'h1C};

  initial begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_all_zero("reset");

    // F1 make / break
    send_byte(8'h05, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h05, 1'b0);

    // Extended arrows
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);

    // Bad parity: frame dropped
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b1);

    // Watchdog abort after 4 data bits (prefix cleared), then F1
    send_abort(8'h3C, 5);
    send_byte(8'h75, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h05, 1'b0);

    // Pause sequence ignored
    send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h77, 1'b0);
    send_byte(8'h05, 1'b0);

    // BAT clears held keys
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    send_byte(8'hAA, 1'b0);

    // Fake shifts unmapped; keypad vs arrow tracking
    send_byte(8'hE0, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);

    // Reset in the middle of a frame
    send_bits(make_frame(8'h72, 1'b0), 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check_all_zero("midreset");
    send_byte(8'h05, 1'b0);

    // Random byte stream
    for (int n = 0; n < 40; n++)
      send_byte(pool[$urandom_range(0, 15)], $urandom_range(0, 7) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
